// File: rtl/alu_pkg.sv
// Shared ALU-side types: widths, per-result status flags and the buffered entry layout.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef struct packed {
        logic carry;
        logic neg;
        logic zero;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        alu_flags_t           flags;
    } alu_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the read port shows zero whenever the FIFO is empty.
module sync_fifo #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers ALU results with push-time flags behind a valid/ready handshake and keeps sticky status bits.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_cout,
    input  logic                       in_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_carry,
    output logic                       out_zero,
    output logic                       out_neg,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       sticky_carry,
    output logic                       sticky_zero,
    input  logic                       clr_sticky
);

    localparam int FLAG_W  = $bits(alu_flags_t);
    localparam int ENTRY_W = WIDTH + FLAG_W;

    alu_flags_t         in_flags;
    alu_flags_t         head_flags;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    // Carry only means something for arithmetic results.
    always_comb begin
        in_flags       = '0;
        in_flags.carry = in_cout && !in_mode;
        in_flags.neg   = in_result[WIDTH-1];
        in_flags.zero  = (in_result == '0);
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign wr_entry  = {in_result, in_flags};

    sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign out_result = rd_entry[ENTRY_W-1:FLAG_W];
    assign head_flags = alu_flags_t'(rd_entry[FLAG_W-1:0]);
    assign out_carry  = head_flags.carry;
    assign out_zero   = head_flags.zero;
    assign out_neg    = head_flags.neg;

    // A push that sets a bit overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_carry <= 1'b0;
            sticky_zero  <= 1'b0;
        end else begin
            sticky_carry <= (sticky_carry && !clr_sticky) || (push && in_flags.carry);
            sticky_zero  <= (sticky_zero && !clr_sticky) || (push && in_flags.zero);
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: queue-based reference model, negedge monitor, random and directed stimulus.
module tb_alu_result_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             z;
        logic             n;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_cout;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_zero;
    logic             out_neg;
    logic [CNT_W-1:0] count;
    logic             sticky_carry;
    logic             sticky_zero;
    logic             clr_sticky;

    exp_t sb[$];
    logic model_sc = 1'b0;
    logic model_sz = 1'b0;
    int   passed = 0;
    int   total  = 0;

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_cout      (in_cout),
        .in_mode      (in_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_zero     (out_zero),
        .out_neg      (out_neg),
        .count        (count),
        .sticky_carry (sticky_carry),
        .sticky_zero  (sticky_zero),
        .clr_sticky   (clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Compares registered DUT state against the model right after a clock edge.
    task automatic checkOutput();
        logic [31:0] head_exp;
        head_exp = '0;
        if (sb.size() != 0)
            head_exp = 32'({sb[0].r, sb[0].c, sb[0].z, sb[0].n});
        check("count", 32'(count), 32'(sb.size()));
        check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("head", 32'({out_result, out_carry, out_zero, out_neg}), head_exp);
        check("sticky_carry", 32'(sticky_carry), 32'(model_sc));
        check("sticky_zero", 32'(sticky_zero), 32'(model_sz));
    endtask

    // Checks the state left by the previous cycle, then drives this cycle and updates the model.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] r, input logic cout,
                                 input logic mode, input logic ordy, input logic clr, input logic rst);
        exp_t e;
        logic accept;
        @(posedge clk);
        #1;
        checkOutput();
        reset      = rst;
        in_valid   = v;
        in_result  = r;
        in_cout    = cout;
        in_mode    = mode;
        out_ready  = ordy;
        clr_sticky = clr;
        if (rst) begin
            sb.delete();
            model_sc = 1'b0;
            model_sz = 1'b0;
        end else begin
            accept = v && (sb.size() < DEPTH);
            e.r = r;
            e.c = (mode == 1'b0) ? cout : 1'b0;
            e.z = (r == 0);
            e.n = r[WIDTH-1];
            if (clr) begin
                model_sc = 1'b0;
                model_sz = 1'b0;
            end
            if (accept) begin
                model_sc = model_sc | e.c;
                model_sz = model_sz | e.z;
                sb.push_back(e);
            end
        end
    endtask

    // Monitor: every accepted pop must match the oldest outstanding expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 32'(out_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("pop_result", 32'(out_result), 32'(e.r));
                check("pop_flags", 32'({out_carry, out_zero, out_neg}), 32'({e.c, e.z, e.n}));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_result = '0; in_cout = 1'b0;
        in_mode = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state, then an arithmetic push held at the head.
        applyStimulus(1, 16'hFFFF, 1, 0, 0, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 0, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);

        // Fill to DEPTH, attempt an overflow push, then drain in order.
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 16'(i), 0, 0, 0, 0, 0);
        applyStimulus(1, 16'h0005, 0, 0, 0, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 0, 0, 0);
        repeat (5) applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);

        // Logic-mode zero result, then clear racing a zero push.
        applyStimulus(1, 16'h0000, 1, 1, 0, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);
        applyStimulus(1, 16'h0000, 1, 1, 1, 1, 0);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);

        // Streaming at one entry per cycle across pointer wrap.
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 16'h0100 + 16'(i), 1'($urandom_range(0, 1)), 0, 1, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);

        // Reset while occupied, with a competing push.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 16'h0A00 + 16'(i), 1, 0, 0, 0, 0);
        applyStimulus(1, 16'h0BBB, 1, 0, 1, 0, 1);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);
        applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);

        // Randomized traffic including backpressure, zero results and clears.
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] r;
            r = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0), 1'b0);
        end

        repeat (DEPTH + 2) applyStimulus(0, 16'h0000, 0, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of `alu16`: captures each ALU result with derived status flags into a small synchronous FIFO and hands it to the consumer over a valid/ready handshake. Decouples the combinational ALU from a consumer that may stall, and keeps sticky status bits for software polling. It sits between the `alu16` outputs and the register-file/writeback side.

## Interface
Parameters:
- `WIDTH`, 16: ALU data width.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ALU result is valid this cycle.
- `in_ready`  out  1  buffer can accept a result.
- `in_result`  in  WIDTH  ALU `result`.
- `in_cout`  in  1  ALU `Cout`, active-high carry.
- `in_mode`  in  1  ALU `mode` used for this result: 0 = arithmetic, 1 = logic.
- `out_valid`  out  1  head entry is available.
- `out_ready`  in  1  consumer accepts head entry.
- `out_result`  out  WIDTH  head result.
- `out_carry`, `out_zero`, `out_neg`  out  1 each  head flags.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `sticky_carry`, `sticky_zero`  out  1 each  sticky status.
- `clr_sticky`  in  1  clears the sticky bits.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Flags are computed at push time and stored with the entry:
  - zero = (`in_result` == 0).
  - neg = `in_result[WIDTH-1]`.
  - carry = `in_cout` when `in_mode`=0; carry is forced to 0 when `in_mode`=1.
- `in_ready` = (`count` != DEPTH). It is not qualified by `out_ready`, so there is no push-through when full.
- `out_valid` = (`count` != 0). While `out_valid`=0, `out_result` and all `out_*` flags are driven to 0.
- Write and read pointers wrap modulo DEPTH.
- `count` changes as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Simultaneous push and pop when `count`=1: the old head is popped and the new entry becomes the head on the next cycle.
- Sticky bits:
  - On each push, `sticky_carry` |= entry carry and `sticky_zero` |= entry zero.
  - `clr_sticky` clears both bits.
  - If `clr_sticky` and a push setting a bit occur in the same cycle, set wins.
- Entry fields, flags, order and `count` are never modified except by push, pop or `reset`.

## Timing
- Reset values:
  - `count`=0, both pointers 0, `out_valid`=0, `in_ready`=1.
  - All `out_*` data/flags 0, `sticky_*`=0.
  - FIFO storage contents need not be reset.
- `reset` asserted mid-operation discards all entries on the next edge. Handshakes in that cycle are ignored.
- Latency: an entry pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N; the consumer can pop it at edge N+1.
- `in_ready`, `out_valid` and `out_*` are functions of registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Sustained throughput is 1 entry/cycle when `out_ready`=1 continuously.

## Structure
- Add to shared package `alu_pkg`:
  - `alu_flags_t`: packed struct {carry, neg, zero}.
  - `alu_entry_t`: packed struct {result[WIDTH-1:0], flags}, with the width taken from the package constant `ALU_WIDTH`=16.
- One sub-module, `sync_fifo`: parameterised by data width and DEPTH, with push/pop/count.
- Flag derivation and sticky logic live in `alu_result_buffer`.
- The top-level bench instantiates `alu16` feeding this block through `alu_if`.

## Test plan
- Reset behaviour: after `reset`, `in_ready`=1, `out_valid`=0, `count`=0, `out_result`=0x0000, and both `sticky_*`=0.
- Arithmetic push: push 0xFFFF with `in_cout`=1 and `in_mode`=0 while `out_ready`=0.
  - Next cycle: `out_result`=0xFFFF, carry=1, neg=1, zero=0, `count`=1.
- Fill and order:
  - Push 0x0001, 0x0002, 0x0003, 0x0004 with `out_ready`=0. Then `count`=4 and `in_ready`=0.
  - A fifth `in_valid` with 0x0005 is not accepted.
  - Drain with `out_ready`=1: results appear in order 1, 2, 3, 4, then `out_valid`=0.
- Logic-mode zero result: push 0x0000 with `in_mode`=1 and `in_cout`=1.
  - Carry=0, zero=1; `sticky_zero`=1 and `sticky_carry` unchanged.
  - In a later cycle, `clr_sticky` plus a push of zero keeps `sticky_zero`=1.
- Streaming: `in_valid`=`out_ready`=1 for 10 cycles with an incrementing result.
  - `count` stays 1 after the first push, one result pops per cycle in order, and pointers wrap across DEPTH.
- Reset while occupied: with `count`=3, assert `reset` for one cycle together with `in_valid`=1.
  - Next cycle: `count`=0, `out_valid`=0, and no entry is retained.
